// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter with refresh slots in front of mem_controller
// Optional refresh scheduler built only when MEM_ARB_REFRESH_EN is defined.
module mem_arbiter #(
  parameter int N_REQ          = 4,
  parameter int CYCLE_LEN      = 4,
  parameter int REFRESH_PERIOD = 64
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [N_REQ-1:0] req_in,
  output logic [N_REQ-1:0] grant_out,
  output logic [N_REQ-1:0] done_out,
  output logic             mem_req_out,
  output logic             refresh_out,
  output logic             busy_out
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(CYCLE_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BUSY,
    S_REFRESH,
    S_PRECHARGE
  } state_t;

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [PW-1:0]  ptr, ptr_n;
  logic [PW-1:0]  win, win_n;
  logic           slot_ref, slot_ref_n;
  logic           pend_arb;
  logic           take_ref;
  logic [PW-1:0]  pick;

  logic [N_REQ-1:0] grant_n, done_n;
  logic             mem_req_n, refresh_n, busy_n;

  // First set request bit searching upward, circularly, from ptr+1.
  function automatic logic [PW-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                            input logic [PW-1:0]    p);
    int idx;
    rr_pick = p;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(p) + k) % N_REQ;
      if (req[idx]) rr_pick = PW'(idx);
    end
  endfunction

  assign pick = rr_pick(req_in, ptr);

`ifdef MEM_ARB_REFRESH_EN
  localparam int RW = $clog2(REFRESH_PERIOD);
  logic [RW-1:0] rcnt;
  logic          pend;
  logic          wrap;

  assign wrap = (rcnt == RW'(REFRESH_PERIOD - 1));

  // A wrap on the edge that consumes the pending refresh re-arms it.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rcnt <= '0;
      pend <= 1'b0;
    end else begin
      rcnt <= wrap ? '0 : rcnt + 1'b1;
      pend <= (pend & ~take_ref) | wrap;
    end
  end

  assign pend_arb = pend;
`else
  assign pend_arb = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    ptr_n      = ptr;
    win_n      = win;
    slot_ref_n = slot_ref;
    take_ref   = 1'b0;
    case (state)
      S_START: begin
        state_n = S_BUSY;
        cnt_n   = CW'(CYCLE_LEN - 1);
      end
      S_BUSY, S_REFRESH: begin
        if (cnt == '0) state_n = S_PRECHARGE;
        else           cnt_n   = cnt - 1'b1;
      end
      default: begin
        if (pend_arb) begin
          state_n    = S_REFRESH;
          cnt_n      = CW'(CYCLE_LEN - 1);
          slot_ref_n = 1'b1;
          take_ref   = 1'b1;
        end else if (|req_in) begin
          state_n    = S_START;
          win_n      = pick;
          ptr_n      = pick;
          slot_ref_n = 1'b0;
        end else begin
          state_n = S_IDLE;
        end
      end
    endcase
  end

  // Outputs are registered copies of what the next state implies.
  always_comb begin
    grant_n   = '0;
    done_n    = '0;
    mem_req_n = (state_n == S_START);
    refresh_n = (state_n == S_REFRESH);
    busy_n    = (state_n != S_IDLE);
    if (state_n == S_START || state_n == S_BUSY)
      grant_n = {{(N_REQ-1){1'b0}}, 1'b1} << win_n;
    if (state_n == S_PRECHARGE && !slot_ref_n)
      done_n = {{(N_REQ-1){1'b0}}, 1'b1} << win_n;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state       <= S_IDLE;
      cnt         <= '0;
      ptr         <= PW'(N_REQ - 1);
      win         <= '0;
      slot_ref    <= 1'b0;
      grant_out   <= '0;
      done_out    <= '0;
      mem_req_out <= 1'b0;
      refresh_out <= 1'b0;
      busy_out    <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      ptr         <= ptr_n;
      win         <= win_n;
      slot_ref    <= slot_ref_n;
      grant_out   <= grant_n;
      done_out    <= done_n;
      mem_req_out <= mem_req_n;
      refresh_out <= refresh_n;
      busy_out    <= busy_n;
    end
  end

endmodule
